// File: rtl/cnn_pkg.sv
// cnn_pkg: shared fixed-point defaults, accumulator sizing and result post-processing helpers
package cnn_pkg;

   localparam int WORD_DEF = 16;
   localparam int FRAC_DEF = 10;

   function automatic int acc_width(input int word, input int frac, input int lanes, input int group_w);
      return 2*word - frac + $clog2(lanes) + group_w;
   endfunction

   function automatic logic signed [63:0] sat_word(input logic signed [63:0] v, input int word, input bit sat);
      logic signed [63:0] hi, lo;
      hi = (64'sd1 <<< (word-1)) - 64'sd1;
      lo = -(64'sd1 <<< (word-1));
      return !sat ? v : v > hi ? hi : v < lo ? lo : v;
   endfunction

   function automatic logic signed [63:0] relu_word(input logic signed [63:0] v, input int word, input bit relu);
      return (relu && v[word-1]) ? 64'sd0 : v;
   endfunction

endpackage

// File: rtl/mac_dot_lane.sv
// mac_dot_lane: one output channel - registered lane products and a floor-shifted sum across lanes
module mac_dot_lane
   import cnn_pkg::*;
#(
   parameter int IN_LANES = 8,
   parameter int WORD     = WORD_DEF,
   parameter int FRAC     = FRAC_DEF,
   parameter int SUM_W    = 2*WORD - FRAC + $clog2(IN_LANES)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load,
   input  logic [IN_LANES*WORD-1:0]   data,
   input  logic [IN_LANES*WORD-1:0]   w,
   output logic signed [SUM_W-1:0]    sum
);

   localparam int P_W = 2*WORD;

   logic signed [P_W-1:0] prod_d [IN_LANES];
   logic signed [P_W-1:0] prod [IN_LANES];

   // full-precision products of each lane pair, lane 0 taken from the MSBs
   always_comb begin
      prod_d = '{default: '0};
      for (int i = 0; i < IN_LANES; i++)
         prod_d[i] = P_W'($signed(data[(IN_LANES-1-i)*WORD +: WORD])) * P_W'($signed(w[(IN_LANES-1-i)*WORD +: WORD]));
   end

   // capture products only on accepted beats so a stall freezes this stage
   always_ff @(posedge clk or posedge rst)
      if (rst)
         prod <= '{default: '0};
      else if (load)
         prod <= prod_d;

   // each product is rescaled with an arithmetic shift (floor) before summing
   always_comb begin
      sum = '0;
      for (int i = 0; i < IN_LANES; i++)
         sum = sum + SUM_W'(prod[i] >>> FRAC);
   end

endmodule

// File: rtl/pointwise_mac_array.sv
// pointwise_mac_array: pipelined 1x1 convolution MAC array with group accumulation, saturation/ReLU and valid/ready output
module pointwise_mac_array
   import cnn_pkg::*;
#(
   parameter int IN_LANES = 8,
   parameter int OUT_CH   = 8,
   parameter int WORD     = WORD_DEF,
   parameter int FRAC     = FRAC_DEF,
   parameter int GROUP_W  = 4,
   parameter int SAT      = 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [GROUP_W-1:0]                cfg_groups,
   input  logic                              cfg_relu,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [IN_LANES*WORD-1:0]          in_data,
   input  logic [OUT_CH*IN_LANES*WORD-1:0]   weight,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [OUT_CH*WORD-1:0]            out_data,
   output logic                              busy
);

   localparam int SUM_W = 2*WORD - FRAC + $clog2(IN_LANES);
   localparam int ACC   = acc_width(WORD, FRAC, IN_LANES, GROUP_W);
   localparam int VW    = IN_LANES*WORD;

   logic                     stall, accept, first, last, s1_valid, s1_last;
   logic [GROUP_W-1:0]       grp_cnt, groups_lat, groups_eff;
   logic signed [SUM_W-1:0]  sum [OUT_CH];
   logic signed [ACC-1:0]    acc [OUT_CH];
   logic signed [ACC-1:0]    total [OUT_CH];
   logic [OUT_CH*WORD-1:0]   res;

   assign stall      = out_valid & ~out_ready;
   assign in_ready   = ~stall;
   assign accept     = in_valid & in_ready;
   assign first      = grp_cnt == '0;
   assign groups_eff = first ? (cfg_groups == '0 ? GROUP_W'(1) : cfg_groups) : groups_lat;
   assign last       = grp_cnt == groups_eff - GROUP_W'(1);
   assign busy       = ~first | s1_valid;

   for (genvar o = 0; o < OUT_CH; o++) begin : g_ch
      mac_dot_lane #(
         .IN_LANES (IN_LANES),
         .WORD     (WORD),
         .FRAC     (FRAC),
         .SUM_W    (SUM_W)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .load (accept),
         .data (in_data),
         .w    (weight[(OUT_CH-1-o)*VW +: VW]),
         .sum  (sum[o])
      );
   end

   // pixel total per channel, then clamp/wrap and optional ReLU, ch 0 at MSBs
   always_comb begin
      total = '{default: '0};
      res   = '0;
      for (int o = 0; o < OUT_CH; o++) begin
         total[o] = acc[o] + ACC'(sum[o]);
         res[(OUT_CH-1-o)*WORD +: WORD] = WORD'(relu_word(sat_word(64'(total[o]), WORD, SAT != 0), WORD, cfg_relu));
      end
   end

   // beat counter within a pixel; group count is frozen on the first beat
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         grp_cnt    <= '0;
         groups_lat <= '0;
      end else if (accept) begin
         grp_cnt <= last ? '0 : grp_cnt + GROUP_W'(1);
         if (first) groups_lat <= groups_eff;
      end

   // stage-1 tags travel with the registered products and hold during a stall
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
      end else if (!stall) begin
         s1_valid <= accept;
         s1_last  <= accept & last;
      end

   // stage-2: accumulate partial sums or emit the finished pixel; output holds until taken
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         acc       <= '{default: '0};
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (!stall) begin
         if (s1_valid)
            for (int o = 0; o < OUT_CH; o++)
               acc[o] <= s1_last ? '0 : total[o];
         if (s1_valid && s1_last) begin
            out_data  <= res;
            out_valid <= 1'b1;
         end else if (out_ready)
            out_valid <= 1'b0;
      end

endmodule

// File: tb/tb_pointwise_mac_array.sv
// tb_pointwise_mac_array: directed self-checking bench for the pointwise MAC array (saturating and wrapping builds)
module tb_pointwise_mac_array;

   localparam int IN_LANES = 8;
   localparam int OUT_CH   = 8;
   localparam int WORD     = 16;
   localparam int GROUP_W  = 4;

   logic                            clk = 1'b0;
   logic                            rst;
   logic [GROUP_W-1:0]              cfg_groups;
   logic                            cfg_relu;
   logic                            in_valid;
   logic [IN_LANES*WORD-1:0]        in_data;
   logic [OUT_CH*IN_LANES*WORD-1:0] weight;
   logic                            out_ready;
   logic                            in_ready, out_valid, busy;
   logic [OUT_CH*WORD-1:0]          out_data;
   logic                            in_ready_w, out_valid_w, busy_w;
   logic [OUT_CH*WORD-1:0]          out_data_w;

   int passed = 0;
   int total  = 0;
   int sent, got, stall_n;
   bit seen;
   logic [WORD-1:0] exp_q [4];

   always #5 clk = ~clk;

   pointwise_mac_array #(.IN_LANES(IN_LANES), .OUT_CH(OUT_CH), .WORD(WORD), .FRAC(10), .GROUP_W(GROUP_W), .SAT(1)) dut (
      .clk(clk), .rst(rst), .cfg_groups(cfg_groups), .cfg_relu(cfg_relu),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .weight(weight),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   pointwise_mac_array #(.IN_LANES(IN_LANES), .OUT_CH(OUT_CH), .WORD(WORD), .FRAC(10), .GROUP_W(GROUP_W), .SAT(0)) dut_w (
      .clk(clk), .rst(rst), .cfg_groups(cfg_groups), .cfg_relu(cfg_relu),
      .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .weight(weight),
      .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w), .busy(busy_w)
   );

   function automatic logic [OUT_CH*WORD-1:0] rep(input logic [WORD-1:0] v);
      return {OUT_CH{v}};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic send(input logic [WORD-1:0] d, input logic [WORD-1:0] w);
      in_data  = {IN_LANES{d}};
      weight   = {OUT_CH*IN_LANES{w}};
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic result(input string tag, input logic [WORD-1:0] exp);
      chk({tag, "_early"}, out_valid, 1'b0);
      @(posedge clk);
      #1;
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_data"}, out_data, rep(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_q      = '{16'h0800, 16'h1000, 16'h1800, 16'h2000};
      rst        = 1'b1;
      cfg_groups = 4'd1;
      cfg_relu   = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      weight     = '0;
      out_ready  = 1'b1;
      #2;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, '0);
      chk("rst_busy", busy, 1'b0);
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      send(16'h0400, 16'h0400);
      chk("unity_busy", busy, 1'b1);
      result("unity", 16'h2000);
      chk("unity_wrap", out_data_w, rep(16'h2000));
      @(posedge clk);
      #1;
      chk("unity_clear", out_valid, 1'b0);
      chk("unity_idle", busy, 1'b0);

      cfg_groups = 4'd3;
      send(16'h0400, 16'h0400);
      chk("multi_b1", out_valid, 1'b0);
      cfg_groups = 4'd1;
      send(16'h0400, 16'h0400);
      chk("multi_b2", out_valid, 1'b0);
      send(16'h0400, 16'h0400);
      result("multi", 16'h6000);

      cfg_groups = 4'd0;
      send(16'h0400, 16'h0400);
      result("grp0", 16'h2000);

      cfg_groups = 4'd1;
      send(16'h2000, 16'h2000);
      result("sat_pos", 16'h7FFF);
      chk("wrap_pos", out_data_w, rep(16'h0000));
      send(16'h2000, 16'hE000);
      result("sat_neg", 16'h8000);

      send(16'h0400, 16'hFC00);
      result("relu_off", 16'hE000);
      cfg_relu = 1'b1;
      send(16'h0400, 16'hFC00);
      result("relu_on", 16'h0000);
      cfg_relu = 1'b0;
      @(posedge clk);
      #1;

      sent    = 0;
      got     = 0;
      stall_n = 0;
      seen    = 1'b0;
      for (int c = 0; c < 60 && got < 4; c++) begin
         if (out_valid && !seen) seen = 1'b1;
         out_ready = !(seen && stall_n < 5);
         if (!out_ready) stall_n++;
         in_valid = sent < 4;
         in_data  = {IN_LANES{16'h0400}};
         weight   = {OUT_CH*IN_LANES{WORD'((sent + 1) * 256)}};
         @(negedge clk);
         if (out_valid && !out_ready) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_stable", out_data, rep(exp_q[got]));
         end
         if (out_valid && out_ready) begin
            chk("bp_order", out_data, rep(exp_q[got]));
            got++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_stalls", stall_n, 5);
      chk("bp_count", got, 4);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_nodup", out_valid, 1'b0);

      cfg_groups = 4'd3;
      send(16'h0400, 16'h0400);
      send(16'h0400, 16'h0400);
      chk("arst_busy_before", busy, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_in_ready", in_ready, 1'b1);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      send(16'h0400, 16'h0400);
      send(16'h0400, 16'h0400);
      chk("arst_b2", out_valid, 1'b0);
      send(16'h0400, 16'h0400);
      result("arst_next", 16'h6000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
